// File: rtl/seven_segment_pkg.sv
// seven_segment_pkg
//   Shared types and constants for the seven-segment display blocks.
//   - SEG_W / CHAR_W : segment vector and character widths
//   - scan_state_e   : scanner FSM states
//   - SEG_*          : active-high glyphs, bit order {a,b,c,d,e,f,g}
package seven_segment_pkg;

    localparam int unsigned SEG_W  = 7;
    localparam int unsigned CHAR_W = 8;

    localparam logic [CHAR_W-1:0] CHAR_SPACE = 8'h20;

    typedef enum logic {
        DRIVE,
        BLANK
    } scan_state_e;

    localparam logic [SEG_W-1:0] SEG_BLANK = 7'b0000000;
    localparam logic [SEG_W-1:0] SEG_0     = 7'b1111110;
    localparam logic [SEG_W-1:0] SEG_1     = 7'b0110000;
    localparam logic [SEG_W-1:0] SEG_2     = 7'b1101101;
    localparam logic [SEG_W-1:0] SEG_3     = 7'b1111001;
    localparam logic [SEG_W-1:0] SEG_4     = 7'b0110011;
    localparam logic [SEG_W-1:0] SEG_5     = 7'b1011011;
    localparam logic [SEG_W-1:0] SEG_6     = 7'b1011111;
    localparam logic [SEG_W-1:0] SEG_7     = 7'b1110000;
    localparam logic [SEG_W-1:0] SEG_8     = 7'b1111111;
    localparam logic [SEG_W-1:0] SEG_9     = 7'b1111011;
    localparam logic [SEG_W-1:0] SEG_A     = 7'b1110111;
    localparam logic [SEG_W-1:0] SEG_B     = 7'b0011111;
    localparam logic [SEG_W-1:0] SEG_C     = 7'b1001110;
    localparam logic [SEG_W-1:0] SEG_D     = 7'b0111101;
    localparam logic [SEG_W-1:0] SEG_E     = 7'b1001111;
    localparam logic [SEG_W-1:0] SEG_F     = 7'b1000111;
    localparam logic [SEG_W-1:0] SEG_H     = 7'b0110111;
    localparam logic [SEG_W-1:0] SEG_L     = 7'b0001110;
    localparam logic [SEG_W-1:0] SEG_P     = 7'b1100111;
    localparam logic [SEG_W-1:0] SEG_U     = 7'b0111110;
    localparam logic [SEG_W-1:0] SEG_DASH  = 7'b0000001;
    localparam logic [SEG_W-1:0] SEG_UNDER = 7'b0001000;

endpackage

// File: rtl/seven_segment_scanner_decoder.sv
// ascii_seg_decoder
//   Pure combinational ASCII to seven-segment decoder, active-high output.
//   Lower-case 'a'-'f' use the upper-case glyphs; unsupported codes blank.
//   Ports:
//     char_i [7:0] : ASCII character
//     seg_o  [6:0] : segments {a,b,c,d,e,f,g}
module ascii_seg_decoder
    import seven_segment_pkg::*;
(
    input  logic [CHAR_W-1:0] char_i,
    output logic [SEG_W-1:0]  seg_o
);

    logic [CHAR_W-1:0] ch;

    always_comb begin
        ch = char_i;
        // fold 'a'-'f' onto 'A'-'F'
        if (char_i >= 8'h61 && char_i <= 8'h66) begin
            ch = char_i - 8'h20;
        end

        seg_o = SEG_BLANK;
        case (ch)
            8'h30: seg_o = SEG_0;
            8'h31: seg_o = SEG_1;
            8'h32: seg_o = SEG_2;
            8'h33: seg_o = SEG_3;
            8'h34: seg_o = SEG_4;
            8'h35: seg_o = SEG_5;
            8'h36: seg_o = SEG_6;
            8'h37: seg_o = SEG_7;
            8'h38: seg_o = SEG_8;
            8'h39: seg_o = SEG_9;
            8'h41: seg_o = SEG_A;
            8'h42: seg_o = SEG_B;
            8'h43: seg_o = SEG_C;
            8'h44: seg_o = SEG_D;
            8'h45: seg_o = SEG_E;
            8'h46: seg_o = SEG_F;
            8'h48: seg_o = SEG_H;
            8'h4C: seg_o = SEG_L;
            8'h50: seg_o = SEG_P;
            8'h55: seg_o = SEG_U;
            8'h2D: seg_o = SEG_DASH;
            8'h5F: seg_o = SEG_UNDER;
            default: seg_o = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seven_segment_scanner.sv
// seven_segment_scanner
//   Time-multiplexed multi-digit seven-segment driver with a writable
//   character buffer, per-digit drive slots and an optional blanking gap.
//   Optional feature macro: SEVSEG_BLINK_EN (adds blink_mask and blink phase).
//   Ports:
//     clk, rst    : clock, asynchronous active-high reset
//     wr_en       : write strobe (one character per cycle)
//     wr_addr     : digit index to write, 0 = rightmost; out-of-range ignored
//     wr_char     : ASCII character
//     blink_mask  : per-digit blink select (SEVSEG_BLINK_EN only)
//     seg         : registered segments {a,b,c,d,e,f,g}
//     dig_en      : registered one-hot digit enable
//     frame_done  : one-cycle pulse at the start of each new scan frame
module seven_segment_scanner
    import seven_segment_pkg::*;
#(
    parameter int NUM_DIGITS     = 4,
    parameter int SCAN_DIV       = 1000,
    parameter int BLANK_CYCLES   = 2,
    parameter int SEG_ACTIVE_LOW = 0,
    parameter int DIG_ACTIVE_LOW = 0,
    parameter int BLINK_DIV      = 64,
    localparam int AW            = $clog2(NUM_DIGITS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [AW-1:0]         wr_addr,
    input  logic [CHAR_W-1:0]     wr_char,
`ifdef SEVSEG_BLINK_EN
    input  logic [NUM_DIGITS-1:0] blink_mask,
`endif
    output logic [SEG_W-1:0]      seg,
    output logic [NUM_DIGITS-1:0] dig_en,
    output logic                  frame_done
);

    localparam int CNT_MAX = (SCAN_DIV > BLANK_CYCLES) ? SCAN_DIV : BLANK_CYCLES;
    localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CW-1:0] DRIVE_LAST = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
    localparam logic [AW-1:0] LAST_IDX   = AW'(NUM_DIGITS - 1);

    // inactive (off) pin levels; XOR with these applies polarity last
    localparam logic [SEG_W-1:0]      SEG_OFF = {SEG_W{SEG_ACTIVE_LOW != 0}};
    localparam logic [NUM_DIGITS-1:0] DIG_OFF = {NUM_DIGITS{DIG_ACTIVE_LOW != 0}};

    logic [CHAR_W-1:0]     buf_q [NUM_DIGITS];
    scan_state_e           state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [AW-1:0]         idx_q, idx_d;
    logic                  wrapped_q, wrapped_d;
    logic [SEG_W-1:0]      seg_q, seg_d;
    logic [NUM_DIGITS-1:0] dig_q, dig_d;
    logic                  frame_q, frame_d;

    logic [SEG_W-1:0]      dec_seg;
    logic [AW-1:0]         idx_next;
    logic                  advance;
    logic                  drive;
    logic [SEG_W-1:0]      seg_raw;
    logic [NUM_DIGITS-1:0] dig_raw;

    // character buffer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
                buf_q[i] <= CHAR_SPACE;
            end
        end else if (wr_en && (int'(wr_addr) < NUM_DIGITS)) begin
            buf_q[wr_addr] <= wr_char;
        end
    end

    ascii_seg_decoder u_decoder (
        .char_i (buf_q[idx_q]),
        .seg_o  (dec_seg)
    );

    // scan FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= DRIVE;
            cnt_q     <= '0;
            idx_q     <= '0;
            wrapped_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            wrapped_q <= wrapped_d;
        end
    end

    assign idx_next = (idx_q == LAST_IDX) ? '0 : idx_q + AW'(1);

    // next-state logic
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        wrapped_d = wrapped_q;
        advance   = 1'b0;

        case (state_q)
            DRIVE: begin
                if (cnt_q == DRIVE_LAST) begin
                    cnt_d = '0;
                    if (BLANK_CYCLES == 0) begin
                        advance = 1'b1;
                    end else begin
                        state_d = BLANK;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            BLANK: begin
                if (cnt_q == BLANK_LAST) begin
                    cnt_d   = '0;
                    state_d = DRIVE;
                    advance = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = DRIVE;
                cnt_d   = '0;
            end
        endcase

        if (advance) begin
            idx_d = idx_next;
            // first wrap arms frame_done so the reset frame never pulses
            if (idx_q == LAST_IDX) begin
                wrapped_d = 1'b1;
            end
        end
    end

`ifdef SEVSEG_BLINK_EN
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

    logic [BW-1:0] fcnt_q, fcnt_d;
    logic          phase_q, phase_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fcnt_q  <= '0;
            phase_q <= 1'b0;
        end else begin
            fcnt_q  <= fcnt_d;
            phase_q <= phase_d;
        end
    end

    // phase advances on the same edge as the pulse, so the new frame's
    // first drive cycle already sees the new phase
    always_comb begin
        fcnt_d  = fcnt_q;
        phase_d = phase_q;
        if (frame_d) begin
            if (fcnt_q == BLINK_LAST) begin
                fcnt_d  = '0;
                phase_d = ~phase_q;
            end else begin
                fcnt_d = fcnt_q + BW'(1);
            end
        end
    end
`endif

    // registered outputs derived from the current state
    always_comb begin
        drive   = (state_q == DRIVE);
        seg_raw = '0;
        dig_raw = '0;
        frame_d = drive && (cnt_q == '0) && (idx_q == '0) && wrapped_q;
        if (drive) begin
            seg_raw        = dec_seg;
            dig_raw[idx_q] = 1'b1;
`ifdef SEVSEG_BLINK_EN
            if (phase_d && blink_mask[idx_q]) begin
                seg_raw = '0;
            end
`endif
        end
        seg_d = seg_raw ^ SEG_OFF;
        dig_d = dig_raw ^ DIG_OFF;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_q   <= SEG_OFF;
            dig_q   <= DIG_OFF;
            frame_q <= 1'b0;
        end else begin
            seg_q   <= seg_d;
            dig_q   <= dig_d;
            frame_q <= frame_d;
        end
    end

    assign seg        = seg_q;
    assign dig_en     = dig_q;
    assign frame_done = frame_q;

endmodule

// File: tb/tb_seven_segment_scanner.sv
// tb_seven_segment_scanner
//   Two scanner instances driven with the same character stream:
//     u_a : 4 digits, 4-cycle slots, 1 blank cycle, active-high pins
//     u_b : 5 digits, 3-cycle slots, no blank gap, active-low pins
//   Expected pin values come from a slot/frame arithmetic model and are
//   queued per clock; a monitor pops and compares after each edge.
//   Optional feature macro: SEVSEG_BLINK_EN.
module tb_seven_segment_scanner;

    localparam int BLINK_DIV = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_en_a = 1'b0, wr_en_b = 1'b0;
    logic [1:0] wr_addr_a = '0;
    logic [2:0] wr_addr_b = '0;
    logic [7:0] wr_char = 8'h00;

    logic [6:0] seg_a, seg_b;
    logic [3:0] dig_a;
    logic [4:0] dig_b;
    logic       fd_a, fd_b;

    localparam logic [3:0] MASK_A = 4'b0001;
    localparam logic [4:0] MASK_B = 5'b00101;

    always #5 clk = ~clk;

    seven_segment_scanner #(
        .NUM_DIGITS(4), .SCAN_DIV(4), .BLANK_CYCLES(1),
        .SEG_ACTIVE_LOW(0), .DIG_ACTIVE_LOW(0), .BLINK_DIV(BLINK_DIV)
    ) u_a (
        .clk(clk), .rst(rst), .wr_en(wr_en_a), .wr_addr(wr_addr_a), .wr_char(wr_char),
`ifdef SEVSEG_BLINK_EN
        .blink_mask(MASK_A),
`endif
        .seg(seg_a), .dig_en(dig_a), .frame_done(fd_a)
    );

    seven_segment_scanner #(
        .NUM_DIGITS(5), .SCAN_DIV(3), .BLANK_CYCLES(0),
        .SEG_ACTIVE_LOW(1), .DIG_ACTIVE_LOW(1), .BLINK_DIV(BLINK_DIV)
    ) u_b (
        .clk(clk), .rst(rst), .wr_en(wr_en_b), .wr_addr(wr_addr_b), .wr_char(wr_char),
`ifdef SEVSEG_BLINK_EN
        .blink_mask(MASK_B),
`endif
        .seg(seg_b), .dig_en(dig_b), .frame_done(fd_b)
    );

    typedef struct {
        int         t;
        logic [6:0] seg_a;
        logic [7:0] dig_a;
        logic       fd_a;
        logic [6:0] seg_b;
        logic [7:0] dig_b;
        logic       fd_b;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    // reference character table (abcdefg)
    string      glyph_chars = "0123456789ABCDEFHLPU-_ ";
    logic [6:0] glyph_codes [23] = '{
        7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70, 7'h7F, 7'h7B,
        7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47,
        7'h37, 7'h0E, 7'h67, 7'h3E, 7'h01, 7'h08, 7'h00
    };
    string      pool = "0123456789ABCDEFabcdefHLPU-_ zhx?8";

    logic [7:0] mbuf_a [8];
    logic [7:0] mbuf_b [8];
    int         t_cnt;

    function automatic logic [6:0] ref_decode(input logic [7:0] c);
        logic [7:0] u;
        u = (c >= "a" && c <= "f") ? c - 8'd32 : c;
        for (int i = 0; i < glyph_chars.len(); i++) begin
            if (glyph_chars[i] == u) return glyph_codes[i];
        end
        return 7'h00;
    endfunction

    // expected pins at the t-th edge after reset release (t >= 1)
    function automatic void model(input int t, input int nd, input int sd, input int bc,
                                  input bit seg_al, input bit dig_al,
                                  input logic [7:0] b [8], input logic [7:0] mask,
                                  output logic [6:0] s, output logic [7:0] d,
                                  output logic fd);
        int per, frm, p, f, dg, w;
        per = sd + bc;
        frm = nd * per;
        p   = (t - 1) % frm;
        f   = (t - 1) / frm;
        dg  = p / per;
        w   = p % per;
        s   = 7'h00;
        d   = 8'h00;
        if (w < sd) begin
            s = ref_decode(b[dg]);
            d = 8'(1 << dg);
`ifdef SEVSEG_BLINK_EN
            if (((f / BLINK_DIV) % 2 == 1) && mask[dg]) s = 7'h00;
`else
            if (f < 0 && mask[0]) s = 7'h00;
`endif
        end
        fd = (p == 0) && (t > 1);
        if (seg_al) s = ~s;
        if (dig_al) d = d ^ 8'((1 << nd) - 1);
    endfunction

    task automatic check(input string name, input int t, input logic [7:0] got,
                         input logic [7:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s t=%0d got=%h want=%h", name, t, got, want);
        end
    endtask

    task automatic reset_model();
        for (int i = 0; i < 8; i++) begin
            mbuf_a[i] = 8'h20;
            mbuf_b[i] = 8'h20;
        end
        t_cnt = 0;
    endtask

    // called at a negedge: drive one cycle of stimulus, queue the expectation
    task automatic step(input bit en, input int addr, input logic [7:0] ch);
        exp_t e;
        wr_en_a   = en && (addr < 4);
        wr_addr_a = 2'(addr);
        wr_en_b   = en;
        wr_addr_b = 3'(addr);
        wr_char   = ch;
        t_cnt++;
        e.t = t_cnt;
        model(t_cnt, 4, 4, 1, 1'b0, 1'b0, mbuf_a, 8'(MASK_A), e.seg_a, e.dig_a, e.fd_a);
        model(t_cnt, 5, 3, 0, 1'b1, 1'b1, mbuf_b, 8'(MASK_B), e.seg_b, e.dig_b, e.fd_b);
        exp_q.push_back(e);
        if (en && addr < 4) mbuf_a[addr] = ch;
        if (en && addr < 5) mbuf_b[addr] = ch;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 0, 8'h00);
    endtask

    task automatic rand_steps(input int n);
        for (int i = 0; i < n; i++) begin
            step($urandom_range(1, 0) == 1, int'($urandom_range(7, 0)),
                 8'(pool[$urandom_range(pool.len() - 1, 0)]));
        end
    endtask

    task automatic check_reset_pins(input string tag);
        check({tag, "_seg_a"}, t_cnt, {1'b0, seg_a}, 8'h00);
        check({tag, "_dig_a"}, t_cnt, {4'h0, dig_a}, 8'h00);
        check({tag, "_fd_a"},  t_cnt, {7'h0, fd_a},  8'h00);
        check({tag, "_seg_b"}, t_cnt, {1'b0, seg_b}, 8'h7F);
        check({tag, "_dig_b"}, t_cnt, {3'h0, dig_b}, 8'h1F);
        check({tag, "_fd_b"},  t_cnt, {7'h0, fd_b},  8'h00);
    endtask

    // monitor: compare DUT pins after each edge against the queued expectation
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("seg_a", e.t, {1'b0, seg_a}, {1'b0, e.seg_a});
            check("dig_a", e.t, {4'h0, dig_a}, e.dig_a);
            check("fd_a",  e.t, {7'h0, fd_a},  {7'h0, e.fd_a});
            check("seg_b", e.t, {1'b0, seg_b}, {1'b0, e.seg_b});
            check("dig_b", e.t, {3'h0, dig_b}, e.dig_b);
            check("fd_b",  e.t, {7'h0, fd_b},  {7'h0, e.fd_b});
        end
    end

    initial begin
        reset_model();
        repeat (3) @(negedge clk);
        check_reset_pins("reset");
        rst = 1'b0;

        // "12AF" into addresses 3..0
        step(1'b1, 3, "1");
        step(1'b1, 2, "2");
        step(1'b1, 1, "A");
        step(1'b1, 0, "F");
        idle(45);

        // unsupported glyph, then out-of-range addresses
        step(1'b1, 1, "z");
        step(1'b1, 5, "8");
        step(1'b1, 7, "E");
        idle(25);

        // write '8' into the digit that is mid-drive on u_a
        while (((t_cnt + 1 - 1) % 20) % 5 != 0) idle(1);
        idle(1);
        step(1'b1, ((t_cnt) % 20) / 5, "8");
        idle(10);

        rand_steps(300);

        // asynchronous reset during u_a's drive of digit 2
        while (((t_cnt) % 20) != 11) idle(1);
        wr_en_a = 1'b0;
        wr_en_b = 1'b0;
        rst = 1'b1;
        #1;
        check_reset_pins("async_rst");
        reset_model();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        idle(25);

        rand_steps(150);
        idle(90);

        @(posedge clk);
        #2;
        check("queue_drained", t_cnt, 8'(exp_q.size()), 8'h00);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
